decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I-subset decode stage with register file and ID/EX pipeline register
//
// Purpose: decodes the IF/ID instruction combinationally, reads the 32-entry
// register file and captures controls, operands, immediate, register indices
// and PC values into the ID/EX register on every rising edge.
//
// Optional feature: define DECODE_RF_BYPASS_EN to forward the writeback value
// to a same-cycle read of the register being written.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_instr_d, i_pc_d, i_pc4_d       instruction, PC and PC+4 from IF/ID
//   i_flush_e                        zero the ID/EX register at the next edge
//   i_regwrite_w, i_rd_w, i_result_w writeback port into the register file
//   o_rs1_d, o_rs2_d                 combinational source indices (hazard unit)
//   o_*_e                            ID/EX register outputs
module decode_stage #(
  parameter int P_DATA_WIDTH = 32,
  parameter int PC_WIDTH     = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_DATA_WIDTH-1:0] i_instr_d,
  input  logic [PC_WIDTH:0]       i_pc_d,
  input  logic [PC_WIDTH:0]       i_pc4_d,
  input  logic                    i_flush_e,
  input  logic                    i_regwrite_w,
  input  logic [4:0]              i_rd_w,
  input  logic [P_DATA_WIDTH-1:0] i_result_w,
  output logic [4:0]              o_rs1_d,
  output logic [4:0]              o_rs2_d,
  output logic                    o_regwrite_e,
  output logic [1:0]              o_resultsrc_e,
  output logic                    o_memwrite_e,
  output logic                    o_branch_e,
  output logic                    o_jump_e,
  output logic [3:0]              o_alucontrol_e,
  output logic                    o_alusrc_e,
  output logic [2:0]              o_funct3_e,
  output logic [P_DATA_WIDTH-1:0] o_rd1_e,
  output logic [P_DATA_WIDTH-1:0] o_rd2_e,
  output logic [P_DATA_WIDTH-1:0] o_immext_e,
  output logic [4:0]              o_rs1_e,
  output logic [4:0]              o_rs2_e,
  output logic [4:0]              o_rd_e,
  output logic [PC_WIDTH:0]       o_pc_e,
  output logic [PC_WIDTH:0]       o_pc4_e
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic                    regwrite;
    logic [1:0]              resultsrc;
    logic                    memwrite;
    logic                    branch;
    logic                    jump;
    logic [3:0]              alucontrol;
    logic                    alusrc;
    logic [2:0]              funct3;
    logic [P_DATA_WIDTH-1:0] rd1;
    logic [P_DATA_WIDTH-1:0] rd2;
    logic [P_DATA_WIDTH-1:0] immext;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [PC_WIDTH:0]       pc;
    logic [PC_WIDTH:0]       pc4;
  } idex_t;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    funct7b5;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [4:0]              rd;
  logic                    regwrite;
  logic [1:0]              resultsrc;
  logic                    memwrite;
  logic                    branch;
  logic                    jump;
  logic                    alusrc;
  logic [3:0]              alucontrol;
  logic [3:0]              alu_arith;
  logic [31:0]             imm32;
  logic [P_DATA_WIDTH-1:0] immext;
  logic [P_DATA_WIDTH-1:0] rd1;
  logic [P_DATA_WIDTH-1:0] rd2;
  logic                    rf_we;
  logic [P_DATA_WIDTH-1:0] rf_q [32];
  idex_t                   idex_d;
  idex_t                   idex_q;

  assign opcode   = i_instr_d[6:0];
  assign funct3   = i_instr_d[14:12];
  assign funct7b5 = i_instr_d[30];
  assign rs1      = i_instr_d[19:15];
  assign rs2      = i_instr_d[24:20];
  assign rd       = i_instr_d[11:7];
  assign o_rs1_d  = rs1;
  assign o_rs2_d  = rs2;

  // funct3 -> ALU op shared by R and I-ALU; SUB only exists for R-type,
  // while SRA is selected by funct7[5] in both forms.
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  alu_arith = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  end

  // Unsupported opcodes (including an all-zero flushed instruction) fall to
  // the defaults and become a bubble.
  always_comb begin
    regwrite   = 1'b0;
    resultsrc  = 2'b00;
    memwrite   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alusrc     = 1'b0;
    alucontrol = ALU_ADD;
    imm32      = 32'd0;
    case (opcode)
      OP_R: begin
        regwrite   = 1'b1;
        alucontrol = alu_arith;
      end
      OP_I_ALU: begin
        regwrite   = 1'b1;
        alusrc     = 1'b1;
        alucontrol = alu_arith;
        imm32      = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
      end
      OP_LOAD: begin
        regwrite  = 1'b1;
        resultsrc = 2'b01;
        alusrc    = 1'b1;
        imm32     = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
      end
      OP_STORE: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        imm32    = {{20{i_instr_d[31]}}, i_instr_d[31:25], i_instr_d[11:7]};
      end
      OP_BRANCH: begin
        branch     = 1'b1;
        alucontrol = ALU_SUB;
        imm32      = {{20{i_instr_d[31]}}, i_instr_d[7], i_instr_d[30:25],
                      i_instr_d[11:8], 1'b0};
      end
      OP_JAL: begin
        regwrite  = 1'b1;
        resultsrc = 2'b10;
        jump      = 1'b1;
        imm32     = {{12{i_instr_d[31]}}, i_instr_d[19:12], i_instr_d[20],
                     i_instr_d[30:21], 1'b0};
      end
      OP_JALR: begin
        regwrite  = 1'b1;
        resultsrc = 2'b10;
        jump      = 1'b1;
        alusrc    = 1'b1;
        imm32     = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
      end
      OP_LUI: begin
        regwrite  = 1'b1;
        resultsrc = 2'b11;
        alusrc    = 1'b1;
        imm32     = {i_instr_d[31:12], 12'd0};
      end
      default: ;
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate to the datapath width.
  assign immext = P_DATA_WIDTH'($signed(imm32));

  assign rf_we = i_regwrite_w && (i_rd_w != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[i_rd_w] <= i_result_w;
    end
  end

  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef DECODE_RF_BYPASS_EN
    // rf_we already excludes x0, so x0 is never forwarded.
    if (rf_we && (i_rd_w == rs1)) rd1 = i_result_w;
    if (rf_we && (i_rd_w == rs2)) rd2 = i_result_w;
`endif
  end

  always_comb begin
    idex_d            = '0;
    if (!i_flush_e) begin
      idex_d.regwrite   = regwrite;
      idex_d.resultsrc  = resultsrc;
      idex_d.memwrite   = memwrite;
      idex_d.branch     = branch;
      idex_d.jump       = jump;
      idex_d.alucontrol = alucontrol;
      idex_d.alusrc     = alusrc;
      idex_d.funct3     = funct3;
      idex_d.rd1        = rd1;
      idex_d.rd2        = rd2;
      idex_d.immext     = immext;
      idex_d.rs1        = rs1;
      idex_d.rs2        = rs2;
      idex_d.rd         = rd;
      idex_d.pc         = i_pc_d;
      idex_d.pc4        = i_pc4_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) idex_q <= '0;
    else          idex_q <= idex_d;
  end

  assign o_regwrite_e   = idex_q.regwrite;
  assign o_resultsrc_e  = idex_q.resultsrc;
  assign o_memwrite_e   = idex_q.memwrite;
  assign o_branch_e     = idex_q.branch;
  assign o_jump_e       = idex_q.jump;
  assign o_alucontrol_e = idex_q.alucontrol;
  assign o_alusrc_e     = idex_q.alusrc;
  assign o_funct3_e     = idex_q.funct3;
  assign o_rd1_e        = idex_q.rd1;
  assign o_rd2_e        = idex_q.rd2;
  assign o_immext_e     = idex_q.immext;
  assign o_rs1_e        = idex_q.rs1;
  assign o_rs2_e        = idex_q.rs2;
  assign o_rd_e         = idex_q.rd;
  assign o_pc_e         = idex_q.pc;
  assign o_pc4_e        = idex_q.pc4;

endmodule
